// File: rtl/irq_pkg.sv
// Shared register map, interrupt bit indices and CTRL field positions for irq_source.
package irq_pkg;

  localparam logic [2:0] CTRL   = 3'd0;
  localparam logic [2:0] LOAD0  = 3'd1;
  localparam logic [2:0] LOAD1  = 3'd2;
  localparam logic [2:0] COUNT0 = 3'd3;
  localparam logic [2:0] COUNT1 = 3'd4;
  localparam logic [2:0] STATUS = 3'd5;

  localparam int IRQ_IO0  = 0;
  localparam int IRQ_IO1  = 1;
  localparam int IRQ_CNT0 = 2;
  localparam int IRQ_CNT1 = 3;

  localparam int CTRL_EN0 = 0;
  localparam int CTRL_EN1 = 1;
  localparam int CTRL_AR0 = 2;
  localparam int CTRL_AR1 = 3;

  localparam int STATUS_OVR_LSB = 8;

endpackage

// File: rtl/irq_timer.sv
// Programmable down-counter: load, enable, optional autoreload, one-cycle event on reaching zero.
// Latency: event is combinational in the cycle COUNT is 1; COUNT reads 0 on the following cycle.
module irq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             autoreload_i,
  input  logic [CNT_W-1:0] reload_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             event_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cur;

  // With autoreload, a zero count is treated as the reload value so the reload and the
  // first decrement of the new period share one cycle, giving a period of exactly LOAD.
  always_comb begin
    cur = count_q;
    if (en_i && autoreload_i && (count_q == '0)) begin
      cur = reload_val_i;
    end
    event_o = en_i && (cur == CNT_W'(1));
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (cur != '0)) begin
      count_d = cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/irq_source.sv
// Interrupt request generator: two synchronised IO edge sources, two timers, per-bit
// pending/in-service/overrun tracking against fetch acknowledges, and a small register file.
module irq_source
  import irq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  io_in,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  interrupts,
  input  logic [3:0]  interrupt_taken,
  input  logic        rti
);

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  io_prev_q;
  logic [SYNC_STAGES:0]        warm_q;
  logic [1:0]                  io_event;

  logic                        wr_ctrl, wr_status;
  logic [1:0]                  wr_load, en_rise, cnt_load, cnt_event;
  logic [3:0]                  ctrl_q, ctrl_d;
  logic [1:0][CNT_W-1:0]       load_q, load_val, count;

  logic [3:0]                  ev;
  logic [3:0]                  pend_q, pend_d, ins_q, ins_d, ovr_q, ovr_d, irq_q, irq_d;

  // Edges are only accepted once the whole chain holds post-reset samples, so a line
  // already high when reset drops is not mistaken for a rising edge.
  assign io_event = sync_q[SYNC_STAGES-1] & ~io_prev_q & {2{warm_q[SYNC_STAGES]}};

  assign wr_ctrl    = we && (addr == CTRL);
  assign wr_status  = we && (addr == STATUS);
  assign wr_load[0] = we && (addr == LOAD0);
  assign wr_load[1] = we && (addr == LOAD1);

  for (genvar n = 0; n < 2; n++) begin : gen_timer
    assign en_rise[n]  = wr_ctrl && wdata[CTRL_EN0+n] && !ctrl_q[CTRL_EN0+n];
    assign cnt_load[n] = wr_load[n] || en_rise[n];
    assign load_val[n] = wr_load[n] ? wdata[CNT_W-1:0] : load_q[n];

    irq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk          (clk),
      .reset        (reset),
      .load_i       (cnt_load[n]),
      .load_val_i   (load_val[n]),
      .en_i         (ctrl_q[CTRL_EN0+n]),
      .autoreload_i (ctrl_q[CTRL_AR0+n]),
      .reload_val_i (load_q[n]),
      .count_o      (count[n]),
      .event_o      (cnt_event[n])
    );
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (cnt_event[n] && !ctrl_q[CTRL_AR0+n]) begin
          ctrl_d[CTRL_EN0+n] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ev           = '0;
    ev[IRQ_IO0]  = io_event[0];
    ev[IRQ_IO1]  = io_event[1];
    ev[IRQ_CNT0] = cnt_event[0];
    ev[IRQ_CNT1] = cnt_event[1];
  end

  // A completing rti is applied before a same-cycle event, so the event sees the freed slot.
  always_comb begin
    pend_d = pend_q;
    ins_d  = ins_q;
    ovr_d  = ovr_q;
    irq_d  = '0;
    if (wr_status) begin
      ovr_d = ovr_q & ~wdata[STATUS_OVR_LSB +: 4];
    end
    for (int n = 0; n < 4; n++) begin
      if (rti && interrupt_taken[n]) begin
        irq_d[n]  = pend_q[n];
        ins_d[n]  = pend_q[n];
        pend_d[n] = 1'b0;
      end
      if (ev[n]) begin
        if (!ins_d[n]) begin
          irq_d[n] = 1'b1;
          ins_d[n] = 1'b1;
        end else if (!pend_d[n]) begin
          pend_d[n] = 1'b1;
        end else begin
          ovr_d[n] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      io_prev_q <= '0;
      warm_q    <= '0;
      ctrl_q    <= '0;
      load_q    <= '0;
      pend_q    <= '0;
      ins_q     <= '0;
      ovr_q     <= '0;
      irq_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], io_in};
      io_prev_q <= sync_q[SYNC_STAGES-1];
      warm_q    <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      ctrl_q    <= ctrl_d;
      for (int n = 0; n < 2; n++) begin
        if (wr_load[n]) begin
          load_q[n] <= wdata[CNT_W-1:0];
        end
      end
      pend_q    <= pend_d;
      ins_q     <= ins_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CTRL:    rdata = {28'd0, ctrl_q};
      LOAD0:   rdata = 32'(load_q[0]);
      LOAD1:   rdata = 32'(load_q[1]);
      COUNT0:  rdata = 32'(count[0]);
      COUNT1:  rdata = 32'(count[1]);
      STATUS:  rdata = {20'd0, ovr_q, ins_q, pend_q};
      default: rdata = '0;
    endcase
  end

  assign interrupts = irq_q;

endmodule
